// File: rtl/pdm_mic_capture.sv
// rtl/pdm_mic_capture.sv - PDM microphone clocking, boxcar decimation to 16-bit PCM and RAM write sequencing
module pdm_mic_capture #(
  parameter int CLK_DIV    = 50,
  parameter int DECIM      = 64,
  parameter int GAIN_SHIFT = 10,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_record,
  output logic              MIC_CLK,
  input  logic              MIC_DATA,
  output logic              MIC_LR_SEL,
  output logic [ADDR_W-1:0] data_addr,
  output logic [15:0]       data_dout,
  output logic              data_we,
  output logic              rec_busy,
  output logic              rec_done
);

  localparam int DW     = $clog2(CLK_DIV);
  localparam int BW     = $clog2(DECIM);
  localparam int OW     = BW + 1;
  localparam int CW_RAW = OW + 1 + GAIN_SHIFT;
  localparam int CW     = (CW_RAW > 27) ? CW_RAW : 27;

  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0]     BIT_LAST  = BW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic signed [CW-1:0] CENTRE  = CW'(DECIM / 2);
  localparam logic signed [CW-1:0] POS_MAX = CW'(32767);
  localparam logic signed [CW-1:0] NEG_MIN = CW'(-32768);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                 state;
  logic [DW-1:0]          div_cnt;
  logic [DW-1:0]          div_nxt;
  logic                   bit_evt;
  logic                   mic_m, mic_s;
  logic                   rec_m, rec_s;
  logic [BW-1:0]          bit_cnt;
  logic [OW-1:0]          ones;
  logic [OW-1:0]          ones_final;
  logic signed [CW-1:0]   centred;
  logic signed [CW-1:0]   scaled;
  logic [15:0]            sample;

  assign MIC_LR_SEL = 1'b0;

  always_comb begin
    div_nxt    = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    bit_evt    = (div_cnt == DIV_LAST);
    ones_final = ones + OW'(mic_s);
    centred    = $signed({{(CW-OW){1'b0}}, ones_final}) - CENTRE;
    scaled     = centred <<< GAIN_SHIFT;
    if (scaled > POS_MAX)
      sample = 16'h7FFF;
    else if (scaled < NEG_MIN)
      sample = 16'h8000;
    else
      sample = scaled[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      MIC_CLK   <= 1'b0;
      mic_m     <= 1'b0;
      mic_s     <= 1'b0;
      rec_m     <= 1'b0;
      rec_s     <= 1'b0;
      bit_cnt   <= '0;
      ones      <= '0;
      data_addr <= '0;
      data_dout <= '0;
      data_we   <= 1'b0;
      rec_busy  <= 1'b0;
      rec_done  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      MIC_CLK <= (div_nxt >= DIV_HALF);
      mic_m   <= MIC_DATA;
      mic_s   <= mic_m;
      rec_m   <= sw_record;
      rec_s   <= rec_m;
      data_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rec_s) begin
            state     <= CAPTURE;
            rec_busy  <= 1'b1;
            bit_cnt   <= '0;
            ones      <= '0;
            data_addr <= '0;
          end
        end
        CAPTURE: begin
          // Address advances after every completed write, even if recording stops on that cycle.
          if (data_we) begin
            if (data_addr == ADDR_LAST) begin
              state    <= DONE;
              rec_busy <= 1'b0;
              rec_done <= 1'b1;
            end else begin
              data_addr <= data_addr + 1'b1;
            end
          end
          if (!rec_s) begin
            state    <= IDLE;
            rec_busy <= 1'b0;
            rec_done <= 1'b0;
          end else if (bit_evt) begin
            if (bit_cnt == BIT_LAST) begin
              data_dout <= sample;
              data_we   <= 1'b1;
              bit_cnt   <= '0;
              ones      <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ones    <= ones_final;
            end
          end
        end
        DONE: begin
          if (!rec_s) begin
            state    <= IDLE;
            rec_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// tb/tb_pdm_mic_capture.sv - scoreboard bench for pdm_mic_capture with a count-of-ones reference model
module tb_pdm_mic_capture;

  localparam int CLK_DIV    = 8;
  localparam int DECIM      = 8;
  localparam int GAIN_SHIFT = 13;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 16;
  localparam int WR_PERIOD  = CLK_DIV * DECIM;

  logic              clk = 1'b0;
  logic              rst;
  logic              sw_record;
  logic              MIC_CLK;
  logic              MIC_DATA;
  logic              MIC_LR_SEL;
  logic [ADDR_W-1:0] data_addr;
  logic [15:0]       data_dout;
  logic              data_we;
  logic              rec_busy;
  logic              rec_done;

  pdm_mic_capture #(
    .CLK_DIV(CLK_DIV), .DECIM(DECIM), .GAIN_SHIFT(GAIN_SHIFT),
    .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sw_record(sw_record), .MIC_CLK(MIC_CLK),
    .MIC_DATA(MIC_DATA), .MIC_LR_SEL(MIC_LR_SEL), .data_addr(data_addr),
    .data_dout(data_dout), .data_we(data_we), .rec_busy(rec_busy), .rec_done(rec_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pcm;
    int addr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_count = 0;
  int   cyc = 0;
  int   last_wr = 0;
  int   ones_acc, bits_acc, nwin;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int pcm_of(input int ones);
    int v;
    v = (ones - DECIM / 2) * (1 << GAIN_SHIFT);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v & 16'hFFFF;
  endfunction

  // Monitor: every RAM write is matched against the oldest expected sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (data_we === 1'b1) begin
        wr_count++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", data_addr, data_dout);
        end else begin
          e = q.pop_front();
          check("pcm", int'(data_dout), e.pcm);
          check("addr", int'(data_addr), e.addr);
        end
        if (data_addr != 0) check("write_spacing", cyc - last_wr, WR_PERIOD);
        last_wr = cyc;
      end
    end
  end

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic start_rec();
    @(negedge MIC_CLK);
    @(negedge clk);
    sw_record = 1'b1;
    ones_acc = 0;
    bits_acc = 0;
    nwin = 0;
  endtask

  task automatic send_bit(input bit b, input bit drop_on_close);
    @(posedge MIC_CLK);
    @(negedge clk);
    MIC_DATA = b;
    ones_acc += int'(b);
    bits_acc++;
    if (bits_acc == DECIM) begin
      if (drop_on_close) begin
        @(negedge clk);
        sw_record = 1'b0;
      end else begin
        if (nwin < DEPTH) q.push_back('{pcm_of(ones_acc), nwin});
        nwin++;
      end
      bits_acc = 0;
      ones_acc = 0;
    end
  endtask

  function automatic bit gen_bit(input int mode, input int pos);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return pos[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic settle_and_check(input string tag, input int exp_addr);
    int wr0;
    wr0 = wr_count;
    repeat (2 * WR_PERIOD) @(negedge clk);
    check({tag, "_no_write"}, wr_count, wr0);
    check({tag, "_queue_drained"}, q.size(), 0);
    check({tag, "_busy"}, int'(rec_busy), 0);
    check({tag, "_addr"}, int'(data_addr), exp_addr);
  endtask

  task automatic stop_rec(input string tag);
    @(negedge MIC_CLK);
    @(negedge clk);
    sw_record = 1'b0;
    settle_and_check(tag, nwin);
  endtask

  task automatic measure_mic_clk(input string tag);
    int high, per;
    bit prev;
    @(posedge MIC_CLK);
    high = 0;
    per = 0;
    prev = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      @(negedge clk);
      if (i > 0 && !prev && MIC_CLK) break;
      if (MIC_CLK) high++;
      per++;
      prev = MIC_CLK;
    end
    check({tag, "_mic_clk_period"}, per, CLK_DIV);
    check({tag, "_mic_clk_high"}, high, CLK_DIV / 2);
    check({tag, "_lr_sel"}, int'(MIC_LR_SEL), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, int'(data_addr), 0);
    check({tag, "_dout"}, int'(data_dout), 0);
    check({tag, "_we"}, int'(data_we), 0);
    check({tag, "_busy"}, int'(rec_busy), 0);
    check({tag, "_done"}, int'(rec_done), 0);
    check({tag, "_mic_clk"}, int'(MIC_CLK), 0);
  endtask

  initial begin
    int nw, part, wr0;
    rst = 1'b0;
    sw_record = 1'b0;
    MIC_DATA = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    check("reset_lr_sel", int'(MIC_LR_SEL), 0);
    rst = 1'b1;
    measure_mic_clk("idle");

    // Constant ones, constant zeros, alternating, random; each stopped mid-window.
    for (int mode = 0; mode < 4; mode++) begin
      nw = 3 + $urandom_range(0, 3);
      part = $urandom_range(1, DECIM - 1);
      start_rec();
      if (mode == 3) begin
        fork
          for (int i = 0; i < nw * DECIM + part; i++) send_bit(gen_bit(mode, i % DECIM), 1'b0);
          measure_mic_clk("capture");
        join
      end else begin
        for (int i = 0; i < nw * DECIM + part; i++) send_bit(gen_bit(mode, i % DECIM), 1'b0);
      end
      stop_rec($sformatf("mode%0d", mode));
    end

    // Deassert lands exactly on the window-closing bit event.
    start_rec();
    for (int i = 0; i < 2 * DECIM; i++) send_bit(gen_bit(3, 0), 1'b0);
    for (int i = 0; i < DECIM; i++) send_bit(gen_bit(3, 0), i == DECIM - 1);
    settle_and_check("coincident", 2);

    // Full recording: exactly DEPTH writes then DONE, extra windows ignored.
    wr0 = wr_count;
    start_rec();
    for (int i = 0; i < (DEPTH + 3) * DECIM; i++) send_bit(gen_bit(3, 0), 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    check("full_writes", wr_count - wr0, DEPTH);
    check("full_done", int'(rec_done), 1);
    check("full_busy", int'(rec_busy), 0);
    check("full_addr", int'(data_addr), DEPTH - 1);
    measure_mic_clk("done");
    sw_record = 1'b0;
    repeat (4 * CLK_DIV) @(negedge clk);
    check("done_cleared", int'(rec_done), 0);

    // Asynchronous reset mid-window.
    start_rec();
    for (int i = 0; i < 2 * DECIM + 3; i++) send_bit(gen_bit(3, 0), 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("async_reset");
    sw_record = 1'b0;
    wr0 = wr_count;
    repeat (2 * WR_PERIOD) @(negedge clk);
    check("reset_no_write", wr_count, wr0);
    check("reset_queue", q.size(), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Recording after reset restarts at address 0.
    start_rec();
    for (int i = 0; i < 2 * DECIM + 1; i++) send_bit(gen_bit(3, 0), 1'b0);
    stop_rec("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
